// File: rtl/book_pkg.sv
// Shared encodings and the price-ordering helper for order-book blocks.
package book_pkg;

  typedef enum logic [1:0] {
    OP_SET    = 2'd0,
    OP_DELETE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_INSERTED  = 3'd1,
    ST_EVICTED   = 3'd2,
    ST_DROPPED   = 3'd3,
    ST_NOT_FOUND = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SL_HOLD  = 3'd0,
    SL_CMD   = 3'd1,
    SL_ABOVE = 3'd2,
    SL_BELOW = 3'd3,
    SL_CLEAR = 3'd4
  } slot_sel_e;

  // True when price a ranks ahead of price b on this side of the book.
  function automatic logic better_than(input logic [63:0] a, input logic [63:0] b,
                                       input logic is_bid);
    return is_bid ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/ladder_slot.sv
// One price level: loads from the command, from the level above (shift down),
// from the level below (shift up), or clears.
module ladder_slot
  import book_pkg::*;
#(
  parameter int PRICE_W = 64,
  parameter int QTY_W   = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  slot_sel_e          sel_i,
  input  logic [PRICE_W-1:0] cmd_price_i,
  input  logic [QTY_W-1:0]   cmd_qty_i,
  input  logic [PRICE_W-1:0] above_price_i,
  input  logic [QTY_W-1:0]   above_qty_i,
  input  logic               above_valid_i,
  input  logic [PRICE_W-1:0] below_price_i,
  input  logic [QTY_W-1:0]   below_qty_i,
  input  logic               below_valid_i,
  output logic [PRICE_W-1:0] price_o,
  output logic [QTY_W-1:0]   qty_o,
  output logic               valid_o
);

  logic [PRICE_W-1:0] price_q;
  logic [QTY_W-1:0]   qty_q;
  logic               valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      price_q <= '0;
      qty_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (sel_i)
        SL_CMD: begin
          price_q <= cmd_price_i;
          qty_q   <= cmd_qty_i;
          valid_q <= 1'b1;
        end
        SL_ABOVE: begin
          price_q <= above_price_i;
          qty_q   <= above_qty_i;
          valid_q <= above_valid_i;
        end
        SL_BELOW: begin
          price_q <= below_price_i;
          qty_q   <= below_qty_i;
          valid_q <= below_valid_i;
        end
        SL_CLEAR: begin
          price_q <= '0;
          qty_q   <= '0;
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign price_o = price_q;
  assign qty_o   = qty_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/book_side_ladder.sv
// One side of an order book kept as a sorted, contiguous, duplicate-free ladder.
// state   | meaning
// S_IDLE  | ready for a command; command fields captured on accept
// S_CMP   | compare captured price against all levels, register hit/insert index
// S_APPLY | update ladder and publish response on the closing edge
module book_side_ladder
  import book_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PRICE_W = 64,
  parameter int QTY_W   = 64,
  parameter bit IS_BID  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [PRICE_W-1:0]         cmd_price,
  input  logic [QTY_W-1:0]           cmd_qty,
  output logic                       resp_valid,
  output logic [2:0]                 resp_status,
  output logic [PRICE_W-1:0]         best_price,
  output logic [QTY_W-1:0]           best_qty,
  output logic                       best_valid,
  output logic [$clog2(DEPTH+1)-1:0] level_count,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [PRICE_W-1:0]         rd_price,
  output logic [QTY_W-1:0]           rd_qty,
  output logic                       rd_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [PRICE_W-1:0] price_q;
  logic [QTY_W-1:0]   qty_q;
  logic               match_hit_q, match_hit_d;
  logic [IDX_W-1:0]   match_idx_q, match_idx_d;
  logic [CNT_W-1:0]   ins_idx_q, ins_idx_d;
  logic               ins_found;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               resp_valid_q;
  status_e            resp_status_q, status_d;
  logic               accept, eff_delete;

  logic [PRICE_W-1:0] lvl_price [DEPTH];
  logic [QTY_W-1:0]   lvl_qty   [DEPTH];
  logic               lvl_valid [DEPTH];
  slot_sel_e          lvl_sel   [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PRICE_W-1:0] above_price, below_price;
    logic [QTY_W-1:0]   above_qty, below_qty;
    logic               above_valid, below_valid;
    if (g == 0) begin : g_first
      assign above_price = '0;
      assign above_qty   = '0;
      assign above_valid = 1'b0;
    end else begin : g_above
      assign above_price = lvl_price[g-1];
      assign above_qty   = lvl_qty[g-1];
      assign above_valid = lvl_valid[g-1];
    end
    // The bottom slot pulls in an empty level, so shift-up clears it.
    if (g == DEPTH-1) begin : g_last
      assign below_price = '0;
      assign below_qty   = '0;
      assign below_valid = 1'b0;
    end else begin : g_below
      assign below_price = lvl_price[g+1];
      assign below_qty   = lvl_qty[g+1];
      assign below_valid = lvl_valid[g+1];
    end
    ladder_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) u_slot (
      .clk_i(clk), .rst_ni(reset), .sel_i(lvl_sel[g]),
      .cmd_price_i(price_q), .cmd_qty_i(qty_q),
      .above_price_i(above_price), .above_qty_i(above_qty), .above_valid_i(above_valid),
      .below_price_i(below_price), .below_qty_i(below_qty), .below_valid_i(below_valid),
      .price_o(lvl_price[g]), .qty_o(lvl_qty[g]), .valid_o(lvl_valid[g])
    );
  end

  assign accept     = cmd_valid && cmd_ready;
  assign eff_delete = (op_q == OP_DELETE) || ((op_q == OP_SET) && (qty_q == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CMP;
      S_CMP:   state_d = S_APPLY;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    count_d   = count_q;
    status_d  = resp_status_q;
    for (int i = 0; i < DEPTH; i++) lvl_sel[i] = SL_HOLD;
    if (state_q == S_APPLY) begin
      status_d = ST_OK;
      if (op_q == OP_CLEAR) begin
        for (int i = 0; i < DEPTH; i++) lvl_sel[i] = SL_CLEAR;
        count_d = '0;
      end else if (eff_delete) begin
        if (match_hit_q) begin
          for (int i = 0; i < DEPTH; i++)
            if (IDX_W'(i) >= match_idx_q && CNT_W'(i) < count_q) lvl_sel[i] = SL_BELOW;
          count_d = count_q - 1'b1;
        end else begin
          status_d = ST_NOT_FOUND;
        end
      end else if (op_q == OP_SET) begin
        if (match_hit_q) begin
          lvl_sel[match_idx_q] = SL_CMD;
        end else if (ins_idx_q < CNT_W'(DEPTH)) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == ins_idx_q) lvl_sel[i] = SL_CMD;
            else if (CNT_W'(i) > ins_idx_q && CNT_W'(i) <= count_q) lvl_sel[i] = SL_ABOVE;
          end
          if (count_q == CNT_W'(DEPTH)) begin
            status_d = ST_EVICTED;
          end else begin
            status_d = ST_INSERTED;
            count_d  = count_q + 1'b1;
          end
        end else begin
          status_d = ST_DROPPED;
        end
      end
    end
  end

  always_comb begin
    match_hit_d = 1'b0;
    match_idx_d = '0;
    ins_idx_d   = count_q;
    ins_found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lvl_valid[i] && (lvl_price[i] == price_q) && !match_hit_d) begin
        match_hit_d = 1'b1;
        match_idx_d = IDX_W'(i);
      end
      if (!ins_found && lvl_valid[i] &&
          better_than(64'(price_q), 64'(lvl_price[i]), IS_BID)) begin
        ins_idx_d = CNT_W'(i);
        ins_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q          <= OP_SET;
      price_q       <= '0;
      qty_q         <= '0;
      match_hit_q   <= 1'b0;
      match_idx_q   <= '0;
      ins_idx_q     <= '0;
      count_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_OK;
    end else begin
      if (accept) begin
        op_q    <= op_e'(cmd_op);
        price_q <= cmd_price;
        qty_q   <= cmd_qty;
      end
      if (state_q == S_CMP) begin
        match_hit_q <= match_hit_d;
        match_idx_q <= match_idx_d;
        ins_idx_q   <= ins_idx_d;
      end
      resp_valid_q  <= (state_q == S_APPLY);
      count_q       <= count_d;
      resp_status_q <= status_d;
    end
  end

  always_comb begin
    rd_price = '0;
    rd_qty   = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_price = lvl_price[i];
        rd_qty   = lvl_qty[i];
        rd_valid = lvl_valid[i];
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign level_count = count_q;
  assign best_price  = lvl_price[0];
  assign best_qty    = lvl_qty[0];
  assign best_valid  = lvl_valid[0];

endmodule

// File: doc/book_side_ladder.md
Name: book_side_ladder

Overview:
- Parametrised successor to the single-slot price level register.
- Holds one side of an order book (bid or ask) as DEPTH sorted price levels, each with a quantity.
- Accepts set/delete/clear commands over a valid/ready handshake and keeps the ladder sorted, contiguous and duplicate-free.
- Publishes top-of-book plus random-access depth reads to downstream arbitrage comparators.

Parameters:
- DEPTH, 8, number of price levels stored (>=2).
- PRICE_W, 64, price width (unsigned).
- QTY_W, 64, quantity width (unsigned).
- IS_BID, 1, 1 = descending order (best = highest price); 0 = ascending order (best = lowest price).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: SET=0, DELETE=1, CLEAR=2, 3 reserved (treated as NOP).
- cmd_price  in  PRICE_W  level price.
- cmd_qty  in  QTY_W  level quantity (SET only).
- resp_valid  out  1  one-cycle completion pulse.
- resp_status  out  3  OK=0, INSERTED=1, EVICTED=2, DROPPED=3, NOT_FOUND=4.
- best_price  out  PRICE_W  level 0 price.
- best_qty  out  QTY_W  level 0 quantity.
- best_valid  out  1  level 0 occupied.
- level_count  out  $clog2(DEPTH+1)  number of occupied levels.
- rd_idx  in  $clog2(DEPTH)  depth read index.
- rd_price  out  PRICE_W  price at rd_idx (combinational).
- rd_qty  out  QTY_W  quantity at rd_idx (combinational).
- rd_valid  out  1  rd_idx occupied; 0 if rd_idx >= DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - All levels: price=0, qty=0, valid=0; level_count=0.
  - FSM to IDLE; cmd_ready=1; resp_valid=0; resp_status=OK.
  - A command in flight is discarded with no response.
- Invariants at all times:
  - Valid levels occupy indices 0..level_count-1.
  - Strictly ordered by price per IS_BID; no duplicate prices.
  - Unoccupied slots read price=0, qty=0.
- FSM states: IDLE -> CMP -> APPLY -> IDLE.
  - cmd_ready=1 only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready, and cmd_op/price/qty are registered.
  - CMP (1 cycle):
    - Parallel compare of the registered price against all valid levels.
    - Registers match_hit, match_idx and ins_idx (first slot where the new price is better than the stored one, else level_count).
  - APPLY (1 cycle): performs the update on the closing edge; the same edge sets resp_valid=1 and resp_status; the FSM returns to IDLE.
  - Latency: accept at edge N; ladder outputs and resp_valid update at edge N+2; next accept possible at edge N+3. resp_valid is high for exactly one cycle.
- SET, qty != 0:
  - Price present: overwrite qty only -> OK.
  - Absent, not full: shift levels ins_idx..count-1 down by one, write at ins_idx, count+1 -> INSERTED.
  - Absent, full, ins_idx < DEPTH: shift down, the worst level (DEPTH-1) falls off, count unchanged -> EVICTED.
  - Absent, full, ins_idx == DEPTH (worse than or equal ordering to worst): no change -> DROPPED.
- SET, qty == 0: identical to DELETE.
- DELETE:
  - Present: shift levels match_idx+1..count-1 up by one, clear the last slot, count-1 -> OK.
  - Absent (including empty ladder) -> NOT_FOUND, no change.
- CLEAR: all levels invalidated and zeroed in APPLY; count=0 -> OK.
- Reserved op: no change -> OK.
- Price 0 is a legal price; occupancy is tracked only by the valid bits.
- cmd_* inputs are ignored outside the accept edge; changes during CMP/APPLY have no effect.
- Quantities are stored verbatim; no accumulation or arithmetic on qty.

Decomposition:
- Shared package book_pkg:
  - op encodings (OP_SET, OP_DELETE, OP_CLEAR).
  - status encodings (ST_OK … ST_NOT_FOUND).
  - FSM state encodings.
  - a better_than(a, b, is_bid) function reused by other book blocks.
- One natural sub-module: ladder_slot.
  - One level register with load-from-cmd, load-from-neighbour-above (shift down), load-from-neighbour-below (shift up) and clear.
  - Instantiated DEPTH times via generate; the top level holds the FSM, comparators and select logic.

Test Plan:
- Reset then idle, IS_BID=1, DEPTH=4:
  - best_valid=0, level_count=0, cmd_ready=1, rd_valid=0 for every idx.
- Insert ordering, IS_BID=1: SET 100/5, SET 102/7, SET 101/3.
  - Each response is INSERTED, 2 cycles after accept.
  - Ladder = 102/7, 101/3, 100/5; best_price=102, level_count=3.
- Update and delete on that ladder:
  - SET 101/9 -> OK, level 1 qty=9.
  - SET 102/0 -> OK; ladder = 101/9, 100/5; level_count=2.
  - DELETE 99 -> NOT_FOUND, no change.
- Full ladder with DEPTH=4 holding 104,103,102,101:
  - SET 105/1 -> EVICTED; ladder = 105,104,103,102.
  - SET 100/1 -> DROPPED; ladder unchanged.
- IS_BID=0 build:
  - SET 50, 48, 49 -> ladder = 48, 49, 50; best_price=48.
  - CLEAR -> level_count=0, best_valid=0.
- Async reset mid-operation:
  - Assert reset during CMP of SET 200/1 -> all outputs return to reset values immediately.
  - No resp_valid pulse.
  - After release, cmd_ready=1 and the ladder is empty.
